// File: rtl/npu_input_packer_if.sv
// Beat-in / vector-out bundle for npu_input_packer.
// Handshake: a beat transfers on a rising clk edge where in_valid & in_ready are both high;
// data_valid is a one-cycle pulse with data_out/padded valid in that same cycle, and no back-pressure exists on it.
interface npu_input_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 64,
    parameter int BEAT_LANES = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH*BEAT_LANES-1:0] in_data;
    logic                             in_last;
    logic [DATA_WIDTH*LANES-1:0]      data_out;
    logic                             data_valid;
    logic                             padded;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, data_out, data_valid, padded
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, data_out, data_valid, padded
    );
endinterface

// File: rtl/npu_input_packer.sv
// Packs BEAT_LANES-wide beats into one LANES-wide NPU input vector, zero-padding short vectors.
// Optional statistics counters are built only when NPU_PACKER_STATS_EN is defined.
module npu_input_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 64,
    parameter int BEAT_LANES = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 flush,
    input  logic [7:0]           gap_cycles,
    npu_input_packer_if.slave    bus,
    output logic                 busy,
    output logic [31:0]          vector_count,
    output logic [15:0]          pad_count,
    output logic [1:0]           o_dbg_state
);
    localparam int NBEATS = LANES / BEAT_LANES;
    localparam int BEAT_W = DATA_WIDTH * BEAT_LANES;
    localparam int VEC_W  = DATA_WIDTH * LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_beat;
    logic [VEC_W-1:0] r_asm;
    logic [VEC_W-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_padded;
    logic [7:0]       r_gap_cnt;
    logic             r_rst_done;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_final;
    logic             w_short;
    logic [VEC_W-1:0] w_next_asm;

    // r_rst_done keeps in_ready low through reset and until the first edge after release.
    assign w_in_ready = r_rst_done & en & ~flush &
                        ((r_state == S_IDLE) | (r_state == S_FILL));
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_final    = (r_beat == LAST_BEAT) | bus.in_last;
    assign w_short    = bus.in_last & (r_beat != LAST_BEAT);

    // Unwritten lanes are already zero, since the assembly register clears on every emit/flush/reset.
    always_comb begin
        w_next_asm = r_asm;
        for (int k = 0; k < NBEATS; k++) begin
            if (r_beat == CW'(k)) begin
                w_next_asm[k*BEAT_W +: BEAT_W] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_asm        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_padded     <= 1'b0;
            r_gap_cnt    <= '0;
            r_rst_done   <= 1'b0;
        end else begin
            r_rst_done   <= 1'b1;
            r_data_valid <= 1'b0;
            r_padded     <= 1'b0;
            case (r_state)
                S_IDLE, S_FILL: begin
                    if (flush) begin
                        r_asm   <= '0;
                        r_beat  <= '0;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        if (w_final) begin
                            // Vector goes out in the EMIT cycle, one cycle after its final beat.
                            r_data_out   <= w_next_asm;
                            r_data_valid <= 1'b1;
                            r_padded     <= w_short;
                            r_asm        <= '0;
                            r_beat       <= '0;
                            r_state      <= S_EMIT;
                        end else begin
                            r_asm   <= w_next_asm;
                            r_beat  <= r_beat + 1'b1;
                            r_state <= S_FILL;
                        end
                    end
                end
                S_EMIT: begin
                    if (gap_cycles == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= gap_cycles;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt <= 8'd1) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.padded     = r_padded;
    assign busy           = (r_state != S_IDLE);
    assign o_dbg_state    = r_state;

`ifdef NPU_PACKER_STATS_EN
    logic [31:0] r_vec_cnt;
    logic [15:0] r_pad_cnt;

    // Counts follow the data_valid pulse, so they update one cycle after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vec_cnt <= '0;
            r_pad_cnt <= '0;
        end else if (r_data_valid) begin
            r_vec_cnt <= r_vec_cnt + 32'd1;
            if (r_padded && (r_pad_cnt != 16'hFFFF)) begin
                r_pad_cnt <= r_pad_cnt + 16'd1;
            end
        end
    end

    assign vector_count = r_vec_cnt;
    assign pad_count    = r_pad_cnt;
`else
    assign vector_count = '0;
    assign pad_count    = '0;
`endif

endmodule

// File: tb/tb_npu_input_packer.sv
// Directed bench for npu_input_packer: full/short vectors, gap, flush, enable hold, reset, stats.
module tb_npu_input_packer;
    localparam int DW = 8;
    localparam int LN = 64;
    localparam int BL = 8;
    localparam int NB = LN / BL;
    localparam int BW = DW * BL;
    localparam int VW = DW * LN;
`ifdef NPU_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  gap_cycles = 8'd0;
    logic        busy;
    logic [31:0] vector_count;
    logic [15:0] pad_count;
    logic [1:0]  dbg_state;

    npu_input_packer_if #(.DATA_WIDTH(DW), .LANES(LN), .BEAT_LANES(BL)) bus ();

    npu_input_packer #(.DATA_WIDTH(DW), .LANES(LN), .BEAT_LANES(BL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .flush        (flush),
        .gap_cycles   (gap_cycles),
        .bus          (bus),
        .busy         (busy),
        .vector_count (vector_count),
        .pad_count    (pad_count),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [VW-1:0] exp_q[$];
    logic          exp_pad_q[$];
    int dv_count    = 0;
    int last_dv_cyc = -1;
    int prev_dv_cyc = -1;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.data_valid) begin
            dv_count++;
            prev_dv_cyc = last_dv_cyc;
            last_dv_cyc = cyc;
            check("dv_expected", VW'(exp_q.size() != 0), VW'(1));
            if (exp_q.size() != 0) begin
                check("data_out", bus.data_out, exp_q.pop_front());
                check("padded", VW'(bus.padded), VW'(exp_pad_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [BW-1:0] rep(input logic [7:0] b);
        return {BL{b}};
    endfunction

    function automatic logic [VW-1:0] make_full(input logic [7:0] base);
        logic [VW-1:0] v;
        logic [7:0]    b;
        v = '0;
        for (int k = 0; k < NB; k++) begin
            b = base + 8'(k);
            v[k*BW +: BW] = rep(b);
        end
        return v;
    endfunction

    task automatic send_beat(input logic [BW-1:0] d, input logic last);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("beat_accept", VW'(bus.in_ready), VW'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_beats(input logic [7:0] base, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            send_beat(rep(base + 8'(k)), 1'b0);
        end
    endtask

    task automatic send_full(input logic [7:0] base, input logic last_on_final);
        exp_q.push_back(make_full(base));
        exp_pad_q.push_back(1'b0);
        for (int k = 0; k < NB; k++) begin
            send_beat(rep(base + 8'(k)), last_on_final && (k == NB - 1));
        end
    endtask

    task automatic send_short(input logic [7:0] b, input int n);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*BW +: BW] = rep(b);
        exp_q.push_back(v);
        exp_pad_q.push_back(n < NB);
        for (int k = 0; k < n; k++) send_beat(rep(b), k == n - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int dv_snap;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        en           = 1'b1;
        #2;
        check("rst_data_out", bus.data_out, '0);
        check("rst_data_valid", VW'(bus.data_valid), VW'(0));
        check("rst_padded", VW'(bus.padded), VW'(0));
        check("rst_in_ready", VW'(bus.in_ready), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_vector_count", VW'(vector_count), VW'(0));
        check("rst_pad_count", VW'(pad_count), VW'(0));
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // full vector, beat k = {8{k}}, gap 0
        send_full(8'h00, 1'b0);
        check("full_dv_latency", VW'(bus.data_valid), VW'(1));
        check("full_padded", VW'(bus.padded), VW'(0));
        idle(1);
        check("full_dv_one_cycle", VW'(bus.data_valid), VW'(0));
        check("padded_idle_zero", VW'(bus.padded), VW'(0));
        check("data_out_hold", bus.data_out, make_full(8'h00));

        // back-to-back at full rate: 9 cycles per vector
        send_full(8'h40, 1'b0);
        send_full(8'h50, 1'b0);
        check("throughput_gap0", VW'(last_dv_cyc - prev_dv_cyc), VW'(9));

        // short vector: 3 beats of AA, last on beat 2
        send_short(8'hAA, 3);
        check("short_dv_latency", VW'(bus.data_valid), VW'(1));
        check("short_padded", VW'(bus.padded), VW'(1));
        idle(2);
        check("short_pad_count", VW'(pad_count), VW'(STATS ? 1 : 0));
        check("short_vector_count", VW'(vector_count), VW'(STATS ? 4 : 0));

        // single-beat short vector straight from IDLE; last on the final beat is not padding
        send_short(8'h5C, 1);
        check("single_padded", VW'(bus.padded), VW'(1));
        send_full(8'h60, 1'b1);
        check("last_on_final_padded", VW'(bus.padded), VW'(0));

        // en low holds a partial vector
        exp_q.push_back(make_full(8'h70));
        exp_pad_q.push_back(1'b0);
        send_beats(8'h70, 0, 2);
        en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = rep(8'h73);
        #1;
        check("en_low_in_ready", VW'(bus.in_ready), VW'(0));
        idle(3);
        check("en_low_busy", VW'(busy), VW'(1));
        en = 1'b1;
        send_beats(8'h70, 3, NB - 1);

        // gap of 4: in_ready low 5 cycles after final beat, pulses 13 cycles apart
        gap_cycles = 8'd4;
        send_full(8'h80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("gap_in_ready_low", VW'(bus.in_ready), VW'(0));
            @(negedge clk);
        end
        check("gap_in_ready_back", VW'(bus.in_ready), VW'(1));
        send_full(8'h90, 1'b0);
        check("gap_pulse_spacing", VW'(last_dv_cyc - prev_dv_cyc), VW'(13));
        idle(6);
        gap_cycles = 8'd0;

        // flush with beat 5 pending: no emit, then a clean vector
        send_beats(8'hA0, 0, 4);
        dv_snap = dv_count;
        bus.in_valid = 1'b1;
        bus.in_data  = rep(8'hA5);
        flush        = 1'b1;
        #1;
        check("flush_in_ready", VW'(bus.in_ready), VW'(0));
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_busy", VW'(busy), VW'(0));
        idle(3);
        check("flush_no_dv", VW'(dv_count), VW'(dv_snap));
        send_full(8'hB0, 1'b0);

        // reset mid-FILL
        idle(2);
        send_beats(8'hC0, 0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_data_out", bus.data_out, '0);
        check("midrst_data_valid", VW'(bus.data_valid), VW'(0));
        check("midrst_in_ready", VW'(bus.in_ready), VW'(0));
        check("midrst_busy", VW'(busy), VW'(0));
        check("midrst_vector_count", VW'(vector_count), VW'(0));
        check("midrst_pad_count", VW'(pad_count), VW'(0));
        @(negedge clk);
        reset_n  = 1'b1;
        dv_count = 0;
        send_full(8'hD0, 1'b0);
        idle(3);
        check("postrst_dv_count", VW'(dv_count), VW'(1));
        check("postrst_vector_count", VW'(vector_count), VW'(STATS ? 1 : 0));

        // nine more full vectors: ten since reset
        for (int i = 0; i < 9; i++) send_full(8'hE0 + 8'(i), 1'b0);
        idle(3);
        check("stats_vector_count", VW'(vector_count), VW'(STATS ? 10 : 0));
        check("stats_pad_count", VW'(pad_count), VW'(0));
        check("scoreboard_drained", VW'(exp_q.size()), VW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/npu_input_packer.md
NPU_INPUT_PACKER -- requirements
Module: npu_input_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, lane width in bits.
REQ-002 SHALL have parameter LANES, default 64, lanes per output vector.
REQ-003 SHALL have parameter BEAT_LANES, default 8, lanes per input beat; LANES is an integer multiple of BEAT_LANES.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, packer enable.
REQ-007 SHALL have port flush, input, 1, synchronous discard of any partial vector.
REQ-008 SHALL have port gap_cycles, input, 8, idle cycles forced after each emitted vector.
REQ-009 SHALL have port in_valid, input, 1, beat valid.
REQ-010 SHALL have port in_ready, output, 1, beat accept.
REQ-011 SHALL have port in_data, input, DATA_WIDTH*BEAT_LANES, beat payload; bits [DATA_WIDTH-1:0] are the lowest lane.
REQ-012 SHALL have port in_last, input, 1, final beat of a short vector.
REQ-013 SHALL have port data_out, output, DATA_WIDTH*LANES, assembled vector; feeds NPU data_in.
REQ-014 SHALL have port data_valid, output, 1, one-cycle pulse when data_out is new.
REQ-015 SHALL have port padded, output, 1, qualifies data_valid: vector was zero-padded.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port vector_count, output, 32, emitted vectors (stats).
REQ-018 SHALL have port pad_count, output, 16, emitted padded vectors (stats).

Function
REQ-019 SHALL implement FSM states IDLE, FILL, EMIT and GAP.
REQ-020 SHALL drive in_ready = en & ~flush & (state IDLE or FILL); a beat is accepted when in_valid & in_ready.
REQ-021 SHALL write accepted beat k (k = 0..LANES/BEAT_LANES-1) into lanes k*BEAT_LANES .. k*BEAT_LANES+BEAT_LANES-1 of an assembly register.
REQ-022 SHALL transition IDLE->FILL on the first accepted beat, unless that beat completes the vector.
REQ-023 SHALL enter EMIT the cycle after accepting the final beat, either beat LANES/BEAT_LANES-1 or any beat with in_last=1.
REQ-024 SHALL, on in_last before the final beat, zero every unwritten lane and set padded with the pulse.
REQ-025 SHALL, in EMIT, assert data_valid for exactly one cycle with data_out = assembled vector; latency is final beat accepted at cycle N -> data_valid at N+1.
REQ-026 SHALL hold data_out at the last emitted vector between pulses; padded is meaningful only with data_valid and is otherwise 0.
REQ-027 SHALL sample gap_cycles in EMIT; 0 -> IDLE next; G>0 -> GAP for exactly G cycles, then IDLE.
REQ-028 SHALL clear the beat counter and assembly register on each emit; the counter wraps to 0 only through EMIT.
REQ-029 SHALL, on flush in IDLE or FILL, discard the partial vector, reset the beat counter and return to IDLE, with no data_valid.
REQ-030 SHALL give flush priority over a simultaneous in_valid/in_last: that beat is not accepted.
REQ-031 SHALL ignore flush in EMIT and GAP; the emit and gap complete normally.
REQ-032 SHALL, with en=0, hold the FSM state and partial vector in IDLE and FILL; EMIT and GAP still complete.
REQ-033 SHALL sustain one vector per LANES/BEAT_LANES+1+gap_cycles cycles at full in_valid (9 cycles with defaults, gap 0).

Reset
REQ-034 SHALL, on reset_n low, immediately force state IDLE, beat counter 0 and assembly register 0.
REQ-035 SHALL reset data_out=0, data_valid=0, padded=0, in_ready=0, busy=0, vector_count=0 and pad_count=0.
REQ-036 SHALL discard a partial vector on reset mid-operation and emit nothing for it after release.
REQ-037 SHALL take the first beat no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-038 SHALL use macro NPU_PACKER_STATS_EN.
- Defined: vector_count increments by 1 per data_valid and wraps at 2^32.
- Defined: pad_count increments per data_valid with padded=1 and saturates at 16'hFFFF.
- Undefined: both ports tie to 0 and no counter flops exist.

Verification
REQ-039 SHALL cover the full vector: 8 beats, beat k = {8{k[7:0]}}, gap 0 -> data_valid at cycle after beat 7, lanes 8k..8k+7 = k, padded=0.
REQ-040 SHALL cover the short vector: 3 beats of 8'hAA, in_last on beat 2 -> data_valid next cycle, lanes 0-23 = 8'hAA, lanes 24-63 = 0, padded=1, pad_count=1.
REQ-041 SHALL cover the gap: gap_cycles=4, back-to-back full vectors -> data_valid pulses 13 cycles apart, in_ready low for 5 cycles after each final beat.
REQ-042 SHALL cover flush: flush asserted with beat 5 and in_valid=1 -> no data_valid; the next 8 beats form a clean vector with lanes 0-7 taken from the new beat 0.
REQ-043 SHALL cover reset mid-FILL: reset_n low after 4 beats -> all outputs 0 asynchronously; after release, 8 beats -> exactly one data_valid, vector_count=1.
REQ-044 SHALL cover the stats macro: NPU_PACKER_STATS_EN undefined, 10 vectors -> vector_count=0 and pad_count=0; defined -> vector_count=10.
